line_arbiter_rr: RTL
====================

Name: line_arbiter_rr

Overview:
- Shares the single cacheline adaptor between the I-cache and D-cache miss/writeback ports.
- Full-line (256-bit) transactions only; one outstanding transaction at a time.
- D-cache has default priority; a starvation counter bounds how long the I-cache can be held off under sustained contention.
- Sits between the two cache pmem ports and the cacheline adaptor inside mp4.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width
- STARVE_LIMIT, 4, max consecutive D-cache grants while the I-cache is waiting; must be ≥1

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- icache_read  in  1  I-cache line read request
- icache_write  in  1  I-cache line write request (tied 0 in mp4, still arbitrated)
- icache_address  in  ADDR_W  I-cache line address
- icache_wdata  in  LINE_W  I-cache writeback line
- icache_resp  out  1  I-cache done pulse
- icache_rdata  out  LINE_W  line returned to I-cache
- dcache_read  in  1  D-cache line read request
- dcache_write  in  1  D-cache line write request
- dcache_address  in  ADDR_W  D-cache line address
- dcache_wdata  in  LINE_W  D-cache writeback line
- dcache_resp  out  1  D-cache done pulse
- dcache_rdata  out  LINE_W  line returned to D-cache
- mem_read  out  1  read to adaptor
- mem_write  out  1  write to adaptor
- mem_address  out  ADDR_W  address to adaptor
- mem_wdata  out  LINE_W  line to adaptor
- mem_resp  in  1  adaptor done
- mem_rdata  in  LINE_W  line from adaptor

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, starve_cnt=0.
  - All outputs 0, including rdata registers.
  - Reset mid-transaction abandons it; no resp is issued.
- FSM states: IDLE, I_BUSY, D_BUSY, DONE_I, DONE_D.
- Request validity: req_x = x_read | x_write. Requesters hold their request stable until they see resp.
- IDLE grant rules:
  - Only dcache requesting → D_BUSY.
  - Only icache requesting → I_BUSY.
  - Both requesting → I_BUSY if starve_cnt==STARVE_LIMIT, else D_BUSY.
  - Neither → stay in IDLE.
- On grant (IDLE→BUSY edge):
  - Register address, wdata and op into the mem_* outputs.
  - mem_read/mem_write are asserted from the first BUSY cycle.
  - Grant latency is 1 cycle from a request seen in IDLE.
- Same-cycle read and write from one requester is illegal; the write wins (assertion fires in simulation).
- BUSY: hold mem_* constant until mem_resp=1, then:
  - Latch mem_rdata into x_rdata (reads only; writes leave rdata unchanged).
  - Drop mem_read/mem_write.
  - Go to DONE_x.
- DONE_x: x_resp=1 for exactly one cycle, then → IDLE. The stale request still visible in DONE is ignored.
- Worst-case turnaround: adaptor latency + 2 cycles. Back-to-back grant is possible on the cycle after DONE.
- starve_cnt, updated on each grant:
  - D grant while icache requesting → saturating increment.
  - I grant, or D grant with icache idle → clear.
  - Width is clog2(STARVE_LIMIT+1).
  - STARVE_LIMIT=1 gives strict alternation under contention.
- mem_resp outside BUSY is ignored.
- Request arrival during BUSY/DONE waits for IDLE.

Optional Feature:
- LINE_ARB_PERF_EN defined adds three 32-bit outputs:
  - perf_i_grants: I-cache grant count.
  - perf_d_grants: D-cache grant count.
  - perf_contend: count of IDLE cycles with both requesting.
- Counters reset to 0, wrap at 2^32, and increment on the grant edge.
- Without the macro: no counters and no ports; behaviour otherwise identical.

Decomposition:
- Package line_arb_pkg:
  - arb_state_e enum (the five states).
  - LINE_W/ADDR_W defaults.
  - typedef line_t, logic [LINE_W-1:0].
- Natural sub-module: line_arb_grant, a combinational grant select plus the starve_cnt register.
- FSM and data registers stay in the top.

Test Plan:
- Idle: single read. Reset release, then dcache_read with addr 0x0000_1000 held; adaptor returns line 0xA5..A5 after 5 cycles → mem_read high 5 cycles, dcache_rdata=0xA5..A5, dcache_resp exactly 1 cycle, icache_resp stays 0.
- Contention: icache_read and dcache_read rise in the same cycle → D granted first; I granted immediately after DONE_D; mem_address sequence is D then I.
- Starvation: icache_read held continuously while the D-cache issues 6 back-to-back requests, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D; starve_cnt cleared after the I grant.
- Writeback: dcache_write with wdata 0x1234..., addr 0x0000_2040 → mem_write=1 with exact wdata/addr held until mem_resp; dcache_rdata unchanged; mem_read stays 0.
- Reset mid-op: reset_n=0 asynchronously during D_BUSY → mem_read drops without waiting for a clock edge; no dcache_resp; after release a fresh request completes normally.
- Spurious resp: mem_resp pulsed in IDLE → no resp outputs, state stays IDLE.

Source files
------------

// File: rtl/line_arb_pkg.sv
// Shared types and defaults for the I/D-cache line arbiter.
//   arb_state_e : arbiter FSM states
//   line_t      : one full cacheline at the default width
package line_arb_pkg;

  localparam int unsigned LINE_W_DFLT = 256;
  localparam int unsigned ADDR_W_DFLT = 32;

  typedef logic [LINE_W_DFLT-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_e;

endpackage

// File: rtl/line_arb_grant.sv
// Grant select for the line arbiter plus the I-cache starvation counter.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   arb_en               : FSM is in IDLE and may issue a grant this cycle
//   req_i, req_d         : I-cache / D-cache request valid
//   grant_i_c, grant_d_c : combinational one-hot grant (both 0 when idle)
module line_arb_grant #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en,
  input  logic req_i,
  input  logic req_d,
  output logic grant_i_c,
  output logic grant_d_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit_c;

  // D-cache wins contention until the I-cache has been passed over STARVE_LIMIT times.
  always_comb begin
    starve_hit_c = (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_d_c    = arb_en & req_d & ~(req_i & starve_hit_c);
    grant_i_c    = arb_en & req_i & (~req_d | starve_hit_c);
  end

  // Count D grants that overtook a waiting I-cache; any other grant clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_d_c && req_i) begin
      if (!starve_hit_c) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else if (grant_i_c || grant_d_c) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/line_arbiter_rr.sv
// Shares one cacheline adaptor between the I-cache and D-cache pmem ports.
// One full-line transaction in flight at a time; D-cache has default priority,
// bounded by a starvation counter in line_arb_grant.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   icache_* / dcache_*               : cache-side request, address, wdata, resp, rdata
//   mem_read/write/address/wdata      : adaptor-side request (registered, held while busy)
//   mem_resp, mem_rdata               : adaptor completion and returned line
// Optional build macro LINE_ARB_PERF_EN adds 32-bit counters
//   perf_i_grants, perf_d_grants, perf_contend.
module line_arbiter_rr
  import line_arb_pkg::*;
#(
  parameter int unsigned LINE_W       = LINE_W_DFLT,
  parameter int unsigned ADDR_W       = ADDR_W_DFLT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_read,
  input  logic              icache_write,
  input  logic [ADDR_W-1:0] icache_address,
  input  logic [LINE_W-1:0] icache_wdata,
  output logic              icache_resp,
  output logic [LINE_W-1:0] icache_rdata,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_resp,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef LINE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_contend
`endif
);

  arb_state_e state, state_nxt;

  logic req_i, req_d;
  logic grant_i_c, grant_d_c;

  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_address_nxt;
  logic [LINE_W-1:0] mem_wdata_nxt;
  logic              icache_resp_nxt, dcache_resp_nxt;
  logic [LINE_W-1:0] icache_rdata_nxt, dcache_rdata_nxt;

  assign req_i = icache_read | icache_write;
  assign req_d = dcache_read | dcache_write;

  line_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .arb_en    (state == IDLE),
    .req_i     (req_i),
    .req_d     (req_d),
    .grant_i_c (grant_i_c),
    .grant_d_c (grant_d_c)
  );

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      icache_resp  <= 1'b0;
      dcache_resp  <= 1'b0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
    end else begin
      state        <= state_nxt;
      mem_read     <= mem_read_nxt;
      mem_write    <= mem_write_nxt;
      mem_address  <= mem_address_nxt;
      mem_wdata    <= mem_wdata_nxt;
      icache_resp  <= icache_resp_nxt;
      dcache_resp  <= dcache_resp_nxt;
      icache_rdata <= icache_rdata_nxt;
      dcache_rdata <= dcache_rdata_nxt;
    end
  end

  // Next-state logic; mem_resp only matters in the BUSY states.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d_c)      state_nxt = D_BUSY;
        else if (grant_i_c) state_nxt = I_BUSY;
      end
      I_BUSY:  if (mem_resp) state_nxt = DONE_I;
      D_BUSY:  if (mem_resp) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output next-values: capture the winner on grant, release and return data on mem_resp.
  always_comb begin
    mem_read_nxt     = mem_read;
    mem_write_nxt    = mem_write;
    mem_address_nxt  = mem_address;
    mem_wdata_nxt    = mem_wdata;
    icache_resp_nxt  = 1'b0;
    dcache_resp_nxt  = 1'b0;
    icache_rdata_nxt = icache_rdata;
    dcache_rdata_nxt = dcache_rdata;
    case (state)
      IDLE: begin
        // A simultaneous read+write is illegal; the write takes precedence.
        if (grant_d_c) begin
          mem_read_nxt    = dcache_read & ~dcache_write;
          mem_write_nxt   = dcache_write;
          mem_address_nxt = dcache_address;
          mem_wdata_nxt   = dcache_wdata;
        end else if (grant_i_c) begin
          mem_read_nxt    = icache_read & ~icache_write;
          mem_write_nxt   = icache_write;
          mem_address_nxt = icache_address;
          mem_wdata_nxt   = icache_wdata;
        end
      end
      I_BUSY: begin
        if (mem_resp) begin
          mem_read_nxt    = 1'b0;
          mem_write_nxt   = 1'b0;
          icache_resp_nxt = 1'b1;
          if (mem_read) icache_rdata_nxt = mem_rdata;
        end
      end
      D_BUSY: begin
        if (mem_resp) begin
          mem_read_nxt    = 1'b0;
          mem_write_nxt   = 1'b0;
          dcache_resp_nxt = 1'b1;
          if (mem_read) dcache_rdata_nxt = mem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifdef LINE_ARB_PERF_EN
  // Grant and contention counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_grants <= 32'd0;
      perf_d_grants <= 32'd0;
      perf_contend  <= 32'd0;
    end else begin
      if (grant_i_c) perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d_c) perf_d_grants <= perf_d_grants + 32'd1;
      if ((state == IDLE) && req_i && req_d) perf_contend <= perf_contend + 32'd1;
    end
  end
`endif

  // Read and write together from one requester is a protocol violation.
  a_no_rw_i: assert property (@(posedge clk) disable iff (!reset_n) !(icache_read && icache_write));
  a_no_rw_d: assert property (@(posedge clk) disable iff (!reset_n) !(dcache_read && dcache_write));

endmodule
